alu_functional_unit: RTL

- One execution pipe downstream of the reservation station. Three instances sit side by side, one each on RS issue slots 0/1/2.
- Accepts one issued op per handshake and computes the ALU result, multiply result or load/store address.
- Holds the result until the writeback arbiter grants it, then drives one wakeup/ROB-complete broadcast.
- Its fu_ready output feeds the RS FUx_ready input.

---
 rtl/alu_functional_unit_if.sv | 31 +++
 rtl/alu_functional_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/alu_functional_unit_if.sv
// alu_functional_unit_if: issue and writeback bus between RS, one ALU pipe and the writeback arbiter
interface alu_functional_unit_if #(parameter int TAG_W = 6);
  logic             issue_valid;
  logic             issue_is_LS;
  logic             issue_alusrc;
  logic [3:0]       issue_alu_type;
  logic [TAG_W-1:0] issue_rd_tag;
  logic [TAG_W-1:0] issue_rob_num;
  logic [31:0]      issue_rs1_val;
  logic [31:0]      issue_rs2_val;
  logic [31:0]      issue_imm;
  logic             wb_grant;
  logic             fu_ready;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_val;
  logic [TAG_W-1:0] wb_rob_num;
  logic             wb_is_LS;
  logic [31:0]      wb_store_data;
  logic             protocol_err;
  modport master (
    output issue_valid, issue_is_LS, issue_alusrc, issue_alu_type, issue_rd_tag, issue_rob_num,
           issue_rs1_val, issue_rs2_val, issue_imm, wb_grant,
    input  fu_ready, wb_valid, wb_tag, wb_val, wb_rob_num, wb_is_LS, wb_store_data, protocol_err
  );
  modport slave (
    input  issue_valid, issue_is_LS, issue_alusrc, issue_alu_type, issue_rd_tag, issue_rob_num,
           issue_rs1_val, issue_rs2_val, issue_imm, wb_grant,
    output fu_ready, wb_valid, wb_tag, wb_val, wb_rob_num, wb_is_LS, wb_store_data, protocol_err
  );
endinterface

// File: rtl/alu_functional_unit.sv
// alu_functional_unit: one RS execution pipe (ALU / multi-cycle MUL / LS address), holds result until wb grant; ALU_FU_READY_BYPASS_EN lets a grant cycle accept the next issue
module alu_functional_unit #(
  parameter int MUL_LATENCY = 4,
  parameter int TAG_W = 6
) (
  input logic clk,
  input logic reset,
  alu_functional_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, WAIT_WB} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] a_q, b_q, b, res;
  logic ready, accept, is_mul, mul_done, grant_done;
  logic valid_q, is_ls_q, err_q;
  logic [TAG_W-1:0] tag_q, rob_q;
  logic [31:0] val_q, store_q;
  assign b = bus.issue_alusrc ? bus.issue_imm : bus.issue_rs2_val;
  assign is_mul = !bus.issue_is_LS && bus.issue_alu_type == 4'd12;
  assign mul_done = state == BUSY && cnt == 4'd0;
  assign grant_done = state == WAIT_WB && bus.wb_grant;
  assign accept = bus.issue_valid && ready;
`ifdef ALU_FU_READY_BYPASS_EN
  assign ready = state == IDLE || grant_done;
`else
  assign ready = state == IDLE;
`endif
  assign bus.fu_ready = ready;
  assign bus.wb_valid = valid_q;
  assign bus.wb_tag = tag_q;
  assign bus.wb_val = val_q;
  assign bus.wb_rob_num = rob_q;
  assign bus.wb_is_LS = is_ls_q;
  assign bus.wb_store_data = store_q;
  assign bus.protocol_err = err_q;
  // single-cycle result: LS address or ALU op on A and the selected B
  always_comb begin
    res = 32'd0;
    if (bus.issue_is_LS) res = bus.issue_rs1_val + bus.issue_imm;
    else
      case (bus.issue_alu_type)
        4'd1:  res = bus.issue_rs1_val + b;
        4'd2:  res = bus.issue_rs1_val - b;
        4'd3:  res = bus.issue_rs1_val & b;
        4'd4:  res = bus.issue_rs1_val | b;
        4'd5:  res = bus.issue_rs1_val ^ b;
        4'd6:  res = bus.issue_rs1_val << b[4:0];
        4'd7:  res = bus.issue_rs1_val >> b[4:0];
        4'd8:  res = $unsigned($signed(bus.issue_rs1_val) >>> b[4:0]);
        4'd9:  res = {31'd0, $signed(bus.issue_rs1_val) < $signed(b)};
        4'd10: res = {31'd0, bus.issue_rs1_val < b};
        4'd11: res = b;
        default: res = 32'd0;
      endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state: a new issue wins, then MUL completion, then grant release
  always_comb begin
    state_nx = state;
    state_nx = accept ? (is_mul ? BUSY : WAIT_WB) : mul_done ? WAIT_WB : grant_done ? IDLE : state;
  end
  // result/tag capture, MUL countdown, grant clearing and sticky protocol error
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= 4'd0;
      a_q <= 32'd0;
      b_q <= 32'd0;
      valid_q <= 1'b0;
      is_ls_q <= 1'b0;
      err_q <= 1'b0;
      tag_q <= '0;
      rob_q <= '0;
      val_q <= 32'd0;
      store_q <= 32'd0;
    end else begin
      if (bus.issue_valid && !ready) err_q <= 1'b1;
      if (accept) begin
        tag_q <= bus.issue_rd_tag;
        rob_q <= bus.issue_rob_num;
        is_ls_q <= bus.issue_is_LS;
        store_q <= bus.issue_is_LS ? bus.issue_rs2_val : 32'd0;
        val_q <= is_mul ? 32'd0 : res;
        valid_q <= !is_mul;
        a_q <= bus.issue_rs1_val;
        b_q <= b;
        cnt <= 4'(MUL_LATENCY - 1);
      end else if (mul_done) begin
        val_q <= a_q * b_q;
        valid_q <= 1'b1;
      end else if (grant_done) begin
        valid_q <= 1'b0;
        tag_q <= '0;
        rob_q <= '0;
        is_ls_q <= 1'b0;
        val_q <= 32'd0;
        store_q <= 32'd0;
      end else if (state == BUSY) cnt <= cnt - 4'd1;
    end
endmodule
